// File: rtl/instruction_fetch_if.sv
// Bus between the IF stage and its surroundings: the pipeline controls from ID/hazard unit,
// the program loader from the debug/UART unit, and the IF/ID register outputs.
interface instruction_fetch_if #(
  parameter int PC_SIZE          = 32,
  parameter int INSTRUCTION_SIZE = 32
);
  logic                        i_enable;
  logic                        i_stall;
  logic                        i_branch;
  logic [PC_SIZE-1:0]          i_branch_pc;
  logic                        i_jump;
  logic [PC_SIZE-1:0]          i_jump_pc;
  logic                        i_load_valid;
  logic [7:0]                  i_load_byte;
  logic                        i_start;
  logic                        i_clear;
  logic [PC_SIZE-1:0]          o_next_seq_pc;
  logic [INSTRUCTION_SIZE-1:0] o_instruction;
  logic [PC_SIZE-1:0]          o_pc;
  logic                        o_halt;
  logic                        o_mem_full;

  modport slave (
    input  i_enable, i_stall, i_branch, i_branch_pc, i_jump, i_jump_pc,
           i_load_valid, i_load_byte, i_start, i_clear,
    output o_next_seq_pc, o_instruction, o_pc, o_halt, o_mem_full
  );

  modport master (
    output i_enable, i_stall, i_branch, i_branch_pc, i_jump, i_jump_pc,
           i_load_valid, i_load_byte, i_start, i_clear,
    input  o_next_seq_pc, o_instruction, o_pc, o_halt, o_mem_full
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC register, program memory with byte-wise loader,
// and the LOAD/RUN/HALT sequencing that starts and stops the pipeline.
module instruction_fetch #(
  parameter int                          PC_SIZE          = 32,
  parameter int                          INSTRUCTION_SIZE = 32,
  parameter int                          MEM_DEPTH        = 64,
  parameter logic [INSTRUCTION_SIZE-1:0] HALT_INSTR       = 32'hFFFFFFFF
) (
  input logic                i_clk,
  input logic                i_reset,
  instruction_fetch_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [PC_SIZE-1:0]          pc_q, pc_d;
  logic [CW-1:0]               count_q, count_d;
  logic [1:0]                  idx_q, idx_d;
  logic [23:0]                 stage_q, stage_d;
  logic [INSTRUCTION_SIZE-1:0] mem_q [MEM_DEPTH];

  logic                        mem_we;
  logic [INSTRUCTION_SIZE-1:0] mem_wdata;
  logic [AW-1:0]               word_idx;
  logic [INSTRUCTION_SIZE-1:0] fetch_word;
  logic                        mem_full;
  logic                        advance;
  logic [PC_SIZE-1:0]          pc_plus4;

  assign word_idx = pc_q[AW+1:2];
  assign mem_full = (count_q == CW'(MEM_DEPTH));
  assign pc_plus4 = pc_q + PC_SIZE'(4);
  assign advance  = (state_q == ST_RUN) && bus.i_enable && !bus.i_stall;

  // Fetch path: words beyond the loaded program read as the halt code
  always_comb begin
    fetch_word = mem_q[word_idx];
    if ({1'b0, word_idx} >= count_q) fetch_word = HALT_INSTR;
  end

  // Next-state, PC update and loader control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    mem_we    = 1'b0;
    mem_wdata = {bus.i_load_byte, stage_q};
    if (bus.i_clear) begin
      state_d = ST_LOAD;
      pc_d    = '0;
      count_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (bus.i_start) begin
            // any partially assembled word is discarded
            state_d = ST_RUN;
            pc_d    = '0;
            idx_d   = '0;
          end else if (bus.i_load_valid && !mem_full) begin
            idx_d = idx_q + 2'd1;
            unique case (idx_q)
              2'd0: stage_d[7:0]   = bus.i_load_byte;
              2'd1: stage_d[15:8]  = bus.i_load_byte;
              2'd2: stage_d[23:16] = bus.i_load_byte;
              default: begin
                mem_we  = 1'b1;
                count_d = count_q + CW'(1);
              end
            endcase
          end
        end
        ST_RUN: begin
          if (advance) begin
            // a redirect means the halt code came from the wrong path
            if (bus.i_branch)                 pc_d = bus.i_branch_pc;
            else if (bus.i_jump)              pc_d = bus.i_jump_pc;
            else if (fetch_word == HALT_INSTR) state_d = ST_HALT;
            else                              pc_d = pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC and loader registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      count_q <= '0;
      idx_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
    end
  end

  // Program memory write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_reset && mem_we) mem_q[count_q[AW-1:0]] <= mem_wdata;
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_next_seq_pc = pc_plus4;
  assign bus.o_instruction = (state_q == ST_RUN) ? fetch_word : '0;
  assign bus.o_halt        = (state_q == ST_HALT);
  assign bus.o_mem_full    = mem_full;
endmodule
